// File: rtl/mx_pkg.sv
// Shared MX format definitions used by the converter and the block serializer.
package mx_pkg;

  localparam int unsigned MX_SCALE_W = 8;
  localparam logic [MX_SCALE_W-1:0] MX_SCALE_NAN = 8'hFF;

  typedef enum logic {
    SER_EMPTY,
    SER_STREAM
  } ser_state_e;

  // True when a block of k elements splits into whole beats of `lanes` elements.
  function automatic bit lanes_divide_k(input int unsigned k, input int unsigned lanes);
    return (lanes != 0) && ((k % lanes) == 0);
  endfunction

endpackage

// File: rtl/mxint_beat_mux.sv
// Selects the lanes-wide beat slice of a captured MX block given the beat index.
module mxint_beat_mux
  import mx_pkg::*;
#(
  parameter int unsigned bit_width = 8,
  parameter int unsigned k         = 32,
  parameter int unsigned lanes     = 4,
  parameter int unsigned idx_w     = 3
) (
  input  logic [bit_width*k-1:0]     blk,
  input  logic [idx_w-1:0]           idx,
  output logic [bit_width*lanes-1:0] data
);

  localparam int unsigned BEATS  = k / lanes;
  localparam int unsigned BEAT_W = bit_width * lanes;

  // Beat b covers elements b*lanes .. b*lanes+lanes-1.
  always_comb begin
    data = '0;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (idx == idx_w'(b)) begin
        data = blk[b*BEAT_W +: BEAT_W];
      end
    end
  end

endmodule

// File: rtl/mxint_block_serializer.sv
// Accepts one MX block per handshake and streams it out as k/lanes framed beats.
module mxint_block_serializer
  import mx_pkg::*;
#(
  parameter int unsigned bit_width = 8,
  parameter int unsigned k         = 32,
  parameter int unsigned lanes     = 4
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst_n,
  input  logic                                         i_in_valid,
  output logic                                         o_in_ready,
  input  logic [bit_width*k-1:0]                       i_mx_vec,
  input  logic [MX_SCALE_W-1:0]                        i_mx_exp,
  output logic                                         o_out_valid,
  input  logic                                         i_out_ready,
  output logic [bit_width*lanes-1:0]                   o_out_data,
  output logic [MX_SCALE_W-1:0]                        o_out_exp,
  output logic                                         o_out_first,
  output logic                                         o_out_last,
  output logic [((k/lanes > 1) ? $clog2(k/lanes) : 1)-1:0] o_out_idx
);

  localparam int unsigned BEATS  = k / lanes;
  localparam int unsigned IDX_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned BEAT_W = bit_width * lanes;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  if (!lanes_divide_k(k, lanes)) begin : g_bad_lanes
    $fatal(1, "mxint_block_serializer: lanes must divide k");
  end

  ser_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [bit_width*k-1:0] blk_q;
  logic [MX_SCALE_W-1:0]  exp_q;
  logic                   load;
  logic                   streaming;
  logic                   at_last;
  logic                   in_hs;
  logic                   out_hs;
  logic [BEAT_W-1:0]      beat_data;

  assign streaming = (state_q == SER_STREAM);
  assign at_last   = (idx_q == LAST_IDX);

  // Ready depends only on state and downstream ready, so no combinational path from i_in_valid.
  assign o_in_ready = i_rst_n && (!streaming || (at_last && i_out_ready));
  assign in_hs      = i_in_valid && o_in_ready;
  assign out_hs     = streaming && i_out_ready;

  // Next-state and beat-index logic; a last-beat handshake may reload in the same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      SER_EMPTY: begin
        if (in_hs) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SER_STREAM;
        end
      end
      SER_STREAM: begin
        if (out_hs) begin
          if (!at_last) begin
            idx_d = idx_q + 1'b1;
          end else if (in_hs) begin
            load  = 1'b1;
            idx_d = '0;
          end else begin
            idx_d   = '0;
            state_d = SER_EMPTY;
          end
        end
      end
      default: begin
        state_d = SER_EMPTY;
        idx_d   = '0;
      end
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= SER_EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Block register: written only on an accepted input handshake.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      blk_q <= '0;
      exp_q <= '0;
    end else if (load) begin
      blk_q <= i_mx_vec;
      exp_q <= i_mx_exp;
    end
  end

  mxint_beat_mux #(
    .bit_width (bit_width),
    .k         (k),
    .lanes     (lanes),
    .idx_w     (IDX_W)
  ) u_beat_mux (
    .blk  (blk_q),
    .idx  (idx_q),
    .data (beat_data)
  );

  // Outputs are zeroed whenever no beat is being presented.
  always_comb begin
    o_out_valid = streaming;
    o_out_data  = streaming ? beat_data : '0;
    o_out_exp   = streaming ? exp_q : '0;
    o_out_first = streaming && (idx_q == '0);
    o_out_last  = streaming && at_last;
    o_out_idx   = streaming ? idx_q : '0;
  end

endmodule

// File: tb/tb_mxint_block_serializer.sv
// Randomized self-checking bench for mxint_block_serializer with a beat-queue reference model.
module tb_mxint_block_serializer;

  localparam int unsigned BW    = 8;
  localparam int unsigned K     = 32;
  localparam int unsigned LANES = 4;
  localparam int unsigned BEATS = K / LANES;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  e;
    logic        first;
    logic        last;
    int unsigned idx;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [255:0] mx_vec;
  logic [7:0]   mx_exp;
  logic [31:0]  out_data;
  logic [7:0]   out_exp;
  logic         out_first, out_last;
  logic [2:0]   out_idx;

  logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready;
  logic [255:0] w_vec;
  logic [7:0]   w_exp;
  logic [255:0] w_out_data;
  logic [7:0]   w_out_exp;
  logic         w_out_first, w_out_last;
  logic [0:0]   w_out_idx;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  beat_t        q[$];
  int unsigned  accepted;

  always #5 clk = ~clk;

  mxint_block_serializer #(.bit_width(BW), .k(K), .lanes(LANES)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_mx_vec(mx_vec), .i_mx_exp(mx_exp),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_data(out_data), .o_out_exp(out_exp),
    .o_out_first(out_first), .o_out_last(out_last), .o_out_idx(out_idx)
  );

  mxint_block_serializer #(.bit_width(BW), .k(K), .lanes(K)) dut_wide (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_in_valid(w_in_valid), .o_in_ready(w_in_ready),
    .i_mx_vec(w_vec), .i_mx_exp(w_exp),
    .o_out_valid(w_out_valid), .i_out_ready(w_out_ready),
    .o_out_data(w_out_data), .o_out_exp(w_out_exp),
    .o_out_first(w_out_first), .o_out_last(w_out_last), .o_out_idx(w_out_idx)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // A block becomes `BEATS` queued beats; beat b carries elements b*LANES..b*LANES+LANES-1.
  task automatic push_block(input logic [255:0] vec, input logic [7:0] e);
    beat_t bt;
    for (int unsigned b = 0; b < BEATS; b++) begin
      bt.data  = vec[b*32 +: 32];
      bt.e     = e;
      bt.first = (b == 0);
      bt.last  = (b == BEATS - 1);
      bt.idx   = b;
      q.push_back(bt);
    end
  endtask

  // One main-DUT cycle: drive, check at negedge, advance model at posedge.
  task automatic step(input logic vld, input logic [255:0] vec, input logic [7:0] e,
                      input logic ordy);
    logic exp_valid, exp_rdy, in_hs, out_hs;
    in_valid  = vld;
    mx_vec    = vec;
    mx_exp    = e;
    out_ready = ordy;
    @(negedge clk);
    exp_valid = (q.size() != 0);
    exp_rdy   = (q.size() == 0) || (q.size() == 1 && ordy);
    check("in_ready", in_ready, exp_rdy);
    check("out_valid", out_valid, exp_valid);
    if (exp_valid) begin
      check("data", out_data, q[0].data);
      check("exp", out_exp, q[0].e);
      check("first", out_first, q[0].first);
      check("last", out_last, q[0].last);
      check("idx", out_idx, q[0].idx[2:0]);
    end else begin
      check("idle_zero", {out_data, out_exp, out_first, out_last, out_idx}, '0);
    end
    in_hs  = vld && exp_rdy;
    out_hs = exp_valid && ordy;
    @(posedge clk);
    #1;
    if (out_hs) void'(q.pop_front());
    if (in_hs) begin
      push_block(vec, e);
      accepted++;
    end
  endtask

  initial begin
    logic [255:0] v, w_prev_vec;
    logic [7:0]   e, w_prev_exp;
    logic         vld, w_prev_valid;

    rst_n = 1'b0;
    in_valid = 1'b0; mx_vec = '0; mx_exp = '0; out_ready = 1'b0;
    w_in_valid = 1'b0; w_vec = '0; w_exp = '0; w_out_ready = 1'b0;
    accepted = 0;

    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_outputs", {out_valid, out_data, out_exp, out_first, out_last, out_idx}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, rand256(), 8'hAA, 1'b1);
    step(1'b0, rand256(), 8'hAA, 1'b0);

    // Single counting block, scale 0x7C
    for (int i = 0; i < 32; i++) v[i*8 +: 8] = 8'(i);
    step(1'b1, v, 8'h7C, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, rand256(), 8'h00, 1'b1);

    // Back-to-back blocks: second held valid until accepted on the first block's last beat
    step(1'b1, rand256(), 8'h10, 1'b1);
    v = rand256();
    for (int i = 0; i < 8; i++) step(1'b1, v, 8'h11, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, rand256(), 8'h00, 1'b1);

    // NaN scale passes through untouched
    step(1'b1, rand256(), 8'hFF, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, rand256(), 8'h00, 1'b1);

    // Random traffic with ~50% downstream ready
    accepted = 0;
    for (int c = 0; c < 6000 && accepted < 100; c++) begin
      vld = ($urandom_range(3) != 0);
      step(vld, rand256(), 8'($urandom), 1'($urandom));
    end
    for (int c = 0; c < 200 && q.size() != 0; c++) step(1'b0, rand256(), 8'h00, 1'($urandom));
    for (int c = 0; c < 20 && q.size() != 0; c++) step(1'b0, rand256(), 8'h00, 1'b1);

    // Reset during beat 3 of a block
    step(1'b1, rand256(), 8'h5A, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, rand256(), 8'h00, 1'b1);
    step(1'b0, rand256(), 8'h00, 1'b0);
    out_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", {out_valid, out_data, out_exp, out_first, out_last, out_idx}, '0);
    check("async_rst_ready", in_ready, 1'b0);
    q.delete();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, rand256(), 8'h00, 1'b1);
    step(1'b0, rand256(), 8'h00, 1'b1);
    step(1'b1, rand256(), 8'h3C, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, rand256(), 8'h00, 1'b1);

    // lanes == k: one block per cycle, every beat is first and last at index 0
    w_prev_valid = 1'b0;
    w_prev_vec   = '0;
    w_prev_exp   = '0;
    w_out_ready  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = rand256();
      e = 8'($urandom);
      w_in_valid = (i < 8);
      w_vec = v;
      w_exp = e;
      @(negedge clk);
      check("w_in_ready", w_in_ready, 1'b1);
      check("w_out_valid", w_out_valid, w_prev_valid);
      if (w_prev_valid) begin
        check("w_data", w_out_data, w_prev_vec);
        check("w_exp", w_out_exp, w_prev_exp);
        check("w_first_last_idx", {w_out_first, w_out_last, w_out_idx}, 3'b110);
      end else begin
        check("w_idle_zero", {w_out_data, w_out_exp, w_out_first, w_out_last, w_out_idx}, '0);
      end
      @(posedge clk);
      #1;
      w_prev_valid = w_in_valid;
      w_prev_vec   = v;
      w_prev_exp   = e;
    end
    w_in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
